main_mem_byte_loader: RTL and testbench

Avalon-MM write master that sits directly upstream of the 4096 x 32 single-port on-chip memory, filling it from an 8-bit Avalon-ST byte stream (e.g. UART or host link). Bytes are packed little-endian into 32-bit words and written one word per cycle, with partial-word byteenables on the final word of a packet. Each packet (SOP..EOP) loads a contiguous image starting at `BASE_ADDR`. Status outputs report completion, word count and error conditions to the CPU-visible register block.

---
 rtl/main_loader_pkg.sv | 25 ++
 rtl/main_loader_packer.sv | 50 +++++
 rtl/main_mem_byte_loader.sv | 213 +++++++++++++++++++++
 tb/tb_main_mem_byte_loader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_loader_pkg.sv
// Shared types and helpers for the byte-stream memory loader.
package main_loader_pkg;

  localparam int unsigned NumLanes = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StWrite,
    StDrop,
    StVrd,
    StVcmp
  } state_e;

  // Lanes 0..count-1 enabled; a count of NumLanes or more enables every lane.
  function automatic logic [NumLanes-1:0] be_from_count(input logic [2:0] count);
    logic [NumLanes-1:0] be;
    be = '0;
    for (int i = 0; i < NumLanes; i++) begin
      if (i < int'(count)) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/main_loader_packer.sv
// Little-endian byte packer: tracks filled lanes, assembles the word and its byteenables.
module main_loader_packer
  import main_loader_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                push_i,
  input  logic                clear_i,
  input  logic [7:0]          byte_i,
  output logic [2:0]          count_o,
  output logic [31:0]         word_o,
  output logic [NumLanes-1:0] be_o
);

  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end
    // A start discards whatever was partially packed.
    if (start_i) begin
      cnt_d  = 3'd1;
      word_d = {24'h0, byte_i};
    end else if (push_i) begin
      word_d[{cnt_q[1:0], 3'b000} +: 8] = byte_i;
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign count_o = cnt_q;
  assign word_o  = word_q;
  assign be_o    = be_from_count(cnt_q);

endmodule

// File: rtl/main_mem_byte_loader.sv
// Avalon-ST byte stream to Avalon-MM word writer filling on-chip memory from BASE_ADDR.
// Define MAIN_LOADER_VERIFY_EN to read back and compare every written word.
module main_mem_byte_loader
  import main_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_startofpacket,
  input  logic                in_endofpacket,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [NumLanes-1:0] mem_byteenable,
  output logic [31:0]         mem_writedata,
  output logic                mem_clken,
  input  logic [31:0]         mem_readdata,
  output logic                done,
  output logic [ADDR_W:0]     word_count,
  output logic                overflow,
  output logic                abort,
  output logic                verify_err
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BASE_ADDR + MAX_WORDS - 1);
  localparam logic [ADDR_W:0]   MaxCount = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     wc_q, wc_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                abort_q, abort_d;
  logic                verr_q, verr_d;
  logic                clken_q;

  logic                accept, start_pkt, commit;
  logic                pk_start, pk_push, pk_clear;
  logic                mem_cs, mem_we;
  logic [2:0]          pk_count;
  logic [31:0]         pk_word;
  logic [NumLanes-1:0] pk_be;

  main_loader_packer u_packer (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .start_i (pk_start),
    .push_i  (pk_push),
    .clear_i (pk_clear),
    .byte_i  (in_data),
    .count_o (pk_count),
    .word_o  (pk_word),
    .be_o    (pk_be)
  );

`ifdef MAIN_LOADER_VERIFY_EN
  logic [31:0] be_mask;
  always_comb begin
    be_mask = '0;
    for (int i = 0; i < NumLanes; i++) be_mask[8*i +: 8] = {8{pk_be[i]}};
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_readdata;
`endif

  // Held off until the cycle after reset so no byte is taken while memory is disabled.
  assign in_ready = clken_q & ((state_q == StIdle) | (state_q == StFill) | (state_q == StDrop));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wc_d      = wc_q;
    last_d    = last_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    abort_d   = abort_q;
    verr_d    = verr_q;
    start_pkt = 1'b0;
    commit    = 1'b0;
    pk_start  = 1'b0;
    pk_push   = 1'b0;
    pk_clear  = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && in_startofpacket) begin
          abort_d   = 1'b0;
          start_pkt = 1'b1;
        end
      end
      StFill: begin
        if (accept) begin
          if (in_startofpacket) begin
            abort_d   = 1'b1;
            start_pkt = 1'b1;
          end else if (wc_q == MaxCount) begin
            ovf_d    = 1'b1;
            pk_clear = 1'b1;
            state_d  = in_endofpacket ? StIdle : StDrop;
          end else begin
            pk_push = 1'b1;
            last_d  = in_endofpacket;
            if (pk_count == 3'd3 || in_endofpacket) state_d = StWrite;
          end
        end
      end
      StWrite: begin
        mem_cs = 1'b1;
        mem_we = 1'b1;
`ifdef MAIN_LOADER_VERIFY_EN
        state_d = StVrd;
`else
        commit = 1'b1;
`endif
      end
      StDrop: begin
        if (accept) begin
          if (in_startofpacket) begin
            abort_d   = 1'b1;
            start_pkt = 1'b1;
          end else if (in_endofpacket) begin
            state_d = StIdle;
          end
        end
      end
`ifdef MAIN_LOADER_VERIFY_EN
      StVrd: begin
        mem_cs  = 1'b1;
        state_d = StVcmp;
      end
      StVcmp: begin
        if (((mem_readdata ^ pk_word) & be_mask) != '0) verr_d = 1'b1;
        commit = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (start_pkt) begin
      pk_start = 1'b1;
      ptr_d    = BaseAddr;
      wc_d     = '0;
      ovf_d    = 1'b0;
      verr_d   = 1'b0;
      last_d   = in_endofpacket;
      state_d  = in_endofpacket ? StWrite : StFill;
    end

    // Word retired: advance pointer (saturating at the last slot) and count.
    if (commit) begin
      pk_clear = 1'b1;
      wc_d     = wc_q + CntOne;
      if (ptr_q != LastAddr) ptr_d = ptr_q + PtrOne;
      if (last_q) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        state_d = StFill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      wc_q    <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
      verr_q  <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wc_q    <= wc_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
      verr_q  <= verr_d;
      clken_q <= 1'b1;
    end
  end

  assign mem_address    = ptr_q;
  assign mem_chipselect = mem_cs;
  assign mem_write      = mem_we;
  assign mem_byteenable = mem_cs ? pk_be : '0;
  assign mem_writedata  = pk_word;
  assign mem_clken      = clken_q;
  assign done           = done_q;
  assign word_count     = wc_q;
  assign overflow       = ovf_q;
  assign abort          = abort_q;
  assign verify_err     = verr_q;

endmodule

// File: tb/tb_main_mem_byte_loader.sv
// Self-checking bench for main_mem_byte_loader: directed packets plus random packets vs a model.
module tb_main_mem_byte_loader;

  localparam int AW    = 5;
  localparam int Base  = 16;
  localparam int MaxW  = 6;
`ifdef MAIN_LOADER_VERIFY_EN
  localparam int WordCyc = 7;
  localparam int DoneLat = 3;
`else
  localparam int WordCyc = 5;
  localparam int DoneLat = 1;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   data;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [3:0]    mem_byteenable;
  logic [31:0]   mem_writedata;
  logic [31:0]   mem_readdata;
  logic          done, overflow, abort, verify_err;
  logic [AW:0]   word_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  acc_t wr_q[$];
  acc_t rd_q[$];
  int   done_cyc[$];
  int   acc_q[$];

  logic [31:0]   mem[32];
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  main_mem_byte_loader #(
    .ADDR_W    (AW),
    .BASE_ADDR (Base),
    .MAX_WORDS (MaxW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_startofpacket (in_sop),
    .in_endofpacket   (in_eop),
    .mem_address      (mem_address),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .done             (done),
    .word_count       (word_count),
    .overflow         (overflow),
    .abort            (abort),
    .verify_err       (verify_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model with one-cycle read latency and optional single-bit corruption on read.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      mem_readdata <= '0;
    end else begin
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= (mem_chipselect && !mem_write) ?
          (mem[mem_address] ^ ((corrupt_en && mem_address == corrupt_addr) ? 32'h1 : 32'h0)) :
          32'h0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_chipselect && mem_write)
        wr_q.push_back('{cyc, mem_address, mem_byteenable, mem_writedata});
      if (mem_chipselect && !mem_write)
        rd_q.push_back('{cyc, mem_address, mem_byteenable, 32'h0});
      if (done) done_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sop, input logic eop, output int acc);
    logic rdy;
    in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%02h got in_ready stuck low, want accept", d);
    end
  endtask

  task automatic send_pkt(input bq_t b, input bit sop, input bit eop, input bit gaps);
    int a;
    for (int i = 0; i < b.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(b[i], sop && i == 0, eop && i == b.size() - 1, a);
      acc_q.push_back(a);
    end
  endtask

  task automatic clear_logs();
    wr_q.delete(); rd_q.delete(); done_cyc.delete(); acc_q.delete();
  endtask

  function automatic bq_t ramp(input int n, input logic [7:0] first);
    bq_t b;
    for (int i = 0; i < n; i++) b.push_back(first + 8'(i));
    return b;
  endfunction

  // Model: word w of a byte image, little-endian, at BASE + w.
  function automatic acc_t pack_word(input bq_t b, input int w);
    acc_t r;
    r.cyc = 0; r.addr = AW'(Base + w); r.be = '0; r.data = '0;
    for (int k = 0; k < 4; k++)
      if (4 * w + k < b.size()) begin
        r.be[k] = 1'b1;
        r.data[8*k +: 8] = b[4*w + k];
      end
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    checks++; if (mem_clken !== 1'b0) begin failures++;
      $display("FAIL reset_clken got %b want 0", mem_clken); end
    checks++; if (in_ready !== 1'b0) begin failures++;
      $display("FAIL reset_ready got %b want 0", in_ready); end
    reset_n = 1'b1;
    idle(1);
    checks++; if (mem_clken !== 1'b1) begin failures++;
      $display("FAIL post_reset_clken got %b want 1", mem_clken); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL post_reset_ready got %b want 1", in_ready); end
    checks++;
    if ({mem_chipselect, mem_write, mem_byteenable, done, overflow, abort, verify_err} !== '0
        || word_count !== '0 || mem_writedata !== '0) begin
      failures++;
      $display("FAIL reset_outputs got cs=%b we=%b be=%h done=%b ovf=%b abt=%b ve=%b wc=%0d wd=%h",
               mem_chipselect, mem_write, mem_byteenable, done, overflow, abort, verify_err,
               word_count, mem_writedata);
    end
  endtask

  task automatic test_full_words();
    clear_logs();
    send_pkt(ramp(8, 8'h01), 1'b1, 1'b1, 1'b0);
    idle(10);
    checks++;
    if (wr_q.size() != 2) begin failures++;
      $display("FAIL full_nwrites got %0d want 2", wr_q.size());
    end else begin
      checks++; if (wr_q[0].addr !== AW'(Base) || wr_q[0].data !== 32'h04030201 ||
                    wr_q[0].be !== 4'hF) begin failures++;
        $display("FAIL full_w0 got a=%0d d=%h be=%h want a=%0d d=04030201 be=f",
                 wr_q[0].addr, wr_q[0].data, wr_q[0].be, Base); end
      checks++; if (wr_q[1].addr !== AW'(Base + 1) || wr_q[1].data !== 32'h08070605 ||
                    wr_q[1].be !== 4'hF) begin failures++;
        $display("FAIL full_w1 got a=%0d d=%h be=%h want a=%0d d=08070605 be=f",
                 wr_q[1].addr, wr_q[1].data, wr_q[1].be, Base + 1); end
      checks++; if (wr_q[0].cyc != acc_q[3]) begin failures++;
        $display("FAIL full_latency got cyc %0d want %0d", wr_q[0].cyc, acc_q[3]); end
      checks++; if (wr_q[1].cyc - wr_q[0].cyc != WordCyc) begin failures++;
        $display("FAIL full_throughput got %0d want %0d", wr_q[1].cyc - wr_q[0].cyc, WordCyc); end
      checks++; if (done_cyc.size() != 1 || done_cyc[0] != wr_q[1].cyc + DoneLat) begin
        failures++;
        $display("FAIL full_done got n=%0d want 1 pulse at %0d", done_cyc.size(),
                 wr_q[1].cyc + DoneLat); end
    end
    checks++; if (word_count !== (AW + 1)'(2) || overflow !== 1'b0 || abort !== 1'b0) begin
      failures++;
      $display("FAIL full_status got wc=%0d ovf=%b abt=%b want 2 0 0", word_count, overflow, abort);
    end
  endtask

  task automatic test_partial();
    clear_logs();
    send_pkt(ramp(6, 8'h01), 1'b1, 1'b1, 1'b0);
    idle(10);
    checks++;
    if (wr_q.size() != 2) begin failures++;
      $display("FAIL partial_nwrites got %0d want 2", wr_q.size());
    end else begin
      checks++; if (wr_q[1].data !== 32'h00000605 || wr_q[1].be !== 4'b0011) begin failures++;
        $display("FAIL partial_w1 got d=%h be=%b want d=00000605 be=0011",
                 wr_q[1].data, wr_q[1].be); end
    end
    checks++; if (word_count !== (AW + 1)'(2) || done_cyc.size() != 1) begin failures++;
      $display("FAIL partial_status got wc=%0d done=%0d want 2 1", word_count, done_cyc.size());
    end
  endtask

  task automatic test_overflow();
    clear_logs();
    send_pkt(ramp(28, 8'h10), 1'b1, 1'b1, 1'b0);
    idle(10);
    checks++;
    if (wr_q.size() != MaxW) begin failures++;
      $display("FAIL ovf_nwrites got %0d want %0d", wr_q.size(), MaxW);
    end else begin
      checks++; if (wr_q[MaxW-1].addr !== AW'(Base + MaxW - 1) ||
                    wr_q[MaxW-1].data !== 32'h27262524) begin failures++;
        $display("FAIL ovf_last got a=%0d d=%h want a=%0d d=27262524",
                 wr_q[MaxW-1].addr, wr_q[MaxW-1].data, Base + MaxW - 1); end
    end
    checks++; if (overflow !== 1'b1 || done_cyc.size() != 0 ||
                  word_count !== (AW + 1)'(MaxW)) begin failures++;
      $display("FAIL ovf_status got ovf=%b done=%0d wc=%0d want 1 0 %0d",
               overflow, done_cyc.size(), word_count, MaxW); end
    checks++; if (acc_q.size() != 28 || in_ready !== 1'b1) begin failures++;
      $display("FAIL ovf_drain got accepted=%0d ready=%b want 28 1", acc_q.size(), in_ready); end
  endtask

  task automatic test_abort();
    bq_t p;
    clear_logs();
    p = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(p, 1'b1, 1'b0, 1'b0);
    p = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(p, 1'b1, 1'b1, 1'b0);
    idle(10);
    checks++;
    if (wr_q.size() != 1) begin failures++;
      $display("FAIL abort_nwrites got %0d want 1", wr_q.size());
    end else begin
      checks++; if (wr_q[0].addr !== AW'(Base) || wr_q[0].data !== 32'h44332211 ||
                    wr_q[0].be !== 4'hF) begin failures++;
        $display("FAIL abort_w0 got a=%0d d=%h be=%h want a=%0d d=44332211 be=f",
                 wr_q[0].addr, wr_q[0].data, wr_q[0].be, Base); end
    end
    checks++; if (abort !== 1'b1 || done_cyc.size() != 1 || word_count !== (AW + 1)'(1)) begin
      failures++;
      $display("FAIL abort_status got abt=%b done=%0d wc=%0d want 1 1 1",
               abort, done_cyc.size(), word_count); end
  endtask

  task automatic test_reset_mid_packet();
    int a;
    clear_logs();
    send(8'h55, 1'b1, 1'b0, a);
    send(8'h66, 1'b0, 1'b0, a);
    reset_n = 1'b0;
    idle(1);
    checks++; if (mem_clken !== 1'b0) begin failures++;
      $display("FAIL midrst_clken got %b want 0", mem_clken); end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), 1'b0, i == 4, a);
    idle(10);
    checks++; if (wr_q.size() != 0 || done_cyc.size() != 0) begin failures++;
      $display("FAIL midrst_writes got writes=%0d done=%0d want 0 0", wr_q.size(), done_cyc.size());
    end
    checks++; if (word_count !== '0 || overflow !== 1'b0 || abort !== 1'b0 ||
                  verify_err !== 1'b0) begin failures++;
      $display("FAIL midrst_status got wc=%0d ovf=%b abt=%b ve=%b want all 0",
               word_count, overflow, abort, verify_err); end
  endtask

`ifdef MAIN_LOADER_VERIFY_EN
  task automatic test_verify();
    clear_logs();
    corrupt_en = 1'b1;
    corrupt_addr = AW'(Base + 1);
    send_pkt(ramp(8, 8'h31), 1'b1, 1'b1, 1'b0);
    idle(12);
    corrupt_en = 1'b0;
    checks++; if (verify_err !== 1'b1) begin failures++;
      $display("FAIL verify_err got %b want 1", verify_err); end
    checks++;
    if (rd_q.size() != 2 || wr_q.size() != 2) begin failures++;
      $display("FAIL verify_reads got reads=%0d writes=%0d want 2 2", rd_q.size(), wr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (rd_q[i].cyc != wr_q[i].cyc + 1 || rd_q[i].addr !== wr_q[i].addr) begin
          failures++;
          $display("FAIL verify_read[%0d] got cyc=%0d a=%0d want cyc=%0d a=%0d", i,
                   rd_q[i].cyc, rd_q[i].addr, wr_q[i].cyc + 1, wr_q[i].addr); end
      end
    end
  endtask
`endif

  task automatic test_random();
    bq_t pre, pkt;
    acc_t exp_q[$];
    int npre, nlen, nw, nwc, a;
    bit ovf;
    for (int it = 0; it < 25; it++) begin
      clear_logs(); exp_q.delete(); pre.delete(); pkt.delete();
      repeat ($urandom_range(0, 3)) send(8'($urandom_range(0, 255)), 1'b0,
                                         1'($urandom_range(0, 1)), a);
      npre = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      nlen = $urandom_range(1, 30);
      for (int i = 0; i < npre; i++) pre.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < nlen; i++) pkt.push_back(8'($urandom_range(0, 255)));
      if (npre > 0) send_pkt(pre, 1'b1, 1'b0, 1'b1);
      send_pkt(pkt, 1'b1, 1'b1, 1'b1);
      idle(12);
      // Aborted prefix writes only its complete words; the packet then restarts at BASE.
      for (int w = 0; w < npre / 4; w++) exp_q.push_back(pack_word(pre, w));
      nw  = (nlen + 3) / 4;
      ovf = nw > MaxW;
      nwc = ovf ? MaxW : nw;
      for (int w = 0; w < nwc; w++) exp_q.push_back(pack_word(pkt, w));
      checks++; if (wr_q.size() != exp_q.size()) begin failures++;
        $display("FAIL rand_nwrites it=%0d got %0d want %0d", it, wr_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
        checks++;
        if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].be !== exp_q[i].be ||
            wr_q[i].data !== exp_q[i].data) begin
          failures++;
          $display("FAIL rand_write it=%0d w=%0d got a=%0d be=%h d=%h want a=%0d be=%h d=%h",
                   it, i, wr_q[i].addr, wr_q[i].be, wr_q[i].data,
                   exp_q[i].addr, exp_q[i].be, exp_q[i].data);
        end
      end
      checks++;
      if (overflow !== ovf || abort !== (npre > 0) || word_count !== (AW + 1)'(nwc) ||
          done_cyc.size() != (ovf ? 0 : 1) || verify_err !== 1'b0) begin
        failures++;
        $display("FAIL rand_status it=%0d got ovf=%b abt=%b wc=%0d done=%0d ve=%b want %b %b %0d %0d 0",
                 it, overflow, abort, word_count, done_cyc.size(), verify_err,
                 ovf, npre > 0, nwc, ovf ? 0 : 1);
      end
`ifdef MAIN_LOADER_VERIFY_EN
      checks++; if (rd_q.size() != wr_q.size()) begin failures++;
        $display("FAIL rand_reads it=%0d got %0d want %0d", it, rd_q.size(), wr_q.size()); end
`else
      checks++; if (rd_q.size() != 0) begin failures++;
        $display("FAIL rand_reads it=%0d got %0d want 0", it, rd_q.size()); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_overflow();
    test_abort();
    test_reset_mid_packet();
`ifdef MAIN_LOADER_VERIFY_EN
    test_verify();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
